paralelo_serial: RTL and testbench

- Transmit-side serializer of the PHY lane; directly upstream of the receive deserializer.
- Takes 8-bit parallel symbols through a valid/ready handshake and shifts them out 1 bit per clk_32f, MSB first.
- Emits a training burst of COM symbols (8'hBC) after enable rises, and inserts 8'hBC as idle filler whenever no valid data is offered.
- Single clock domain: the byte rate (4f) is derived internally from an 8-cycle bit counter.

---
 rtl/phy_pkg.sv | 11 +
 rtl/shift_reg_piso.sv | 25 ++
 rtl/paralelo_serial.sv | 101 ++++++++++
 tb/tb_paralelo_serial.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared PHY lane definitions: symbol width, COM symbol, lane FSM encoding.
package phy_pkg;
  localparam int SYM_W = 8;
  localparam logic [SYM_W-1:0] COM_SYMBOL = 8'hBC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;
endpackage

// File: rtl/shift_reg_piso.sv
// 8-bit parallel-in serial-out register, MSB first; load puts bit 7 straight on ser.
module shift_reg_piso
  import phy_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SYM_W-1:0] sym,
  output logic             ser
);
  logic [SYM_W-2:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser   <= 1'b0;
      shreg <= '0;
    end else if (load) begin
      ser   <= sym[SYM_W-1];
      shreg <= sym[SYM_W-2:0];
    end else begin
      ser   <= shreg[SYM_W-2];
      shreg <= {shreg[SYM_W-3:0], 1'b0};
    end
  end
endmodule

// File: rtl/paralelo_serial.sv
// Transmit serializer: COM training burst, valid/ready symbol intake, MSB-first
// serial output at one bit per clk_32f with the byte rate from a 3-bit counter.
module paralelo_serial
  import phy_pkg::*;
#(
  parameter int               TRAIN_SYMBOLS = 8,
  parameter logic [SYM_W-1:0] IDLE_SYMBOL   = COM_SYMBOL
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             valid_in,
  input  logic [SYM_W-1:0] data_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             sym_start,
  output logic             active_out,
  output logic             collision
);
  localparam int TCW = $clog2(TRAIN_SYMBOLS + 1);

  state_t           state, state_n;
  logic [2:0]       bit_cnt;
  logic [TCW-1:0]   train_cnt, train_cnt_n;
  logic [SYM_W-1:0] sym;
  logic             boundary, sym_start_n, collision_n;

  assign boundary   = (bit_cnt == 3'd0);
  assign active_out = (state == ACTIVE);
  assign ready_out  = active_out && boundary && enable;

  // All decisions are taken only in the boundary cycle; mid-symbol inputs are ignored.
  always_comb begin
    state_n     = state;
    train_cnt_n = train_cnt;
    sym         = '0;
    sym_start_n = 1'b0;
    collision_n = 1'b0;
    if (boundary) begin
      case (state)
        IDLE: begin
          if (enable) begin
            state_n     = TRAIN;
            train_cnt_n = TCW'(1);
            sym         = IDLE_SYMBOL;
            sym_start_n = 1'b1;
          end
        end
        TRAIN: begin
          if (!enable) begin
            state_n     = IDLE;
            train_cnt_n = '0;
          end else begin
            train_cnt_n = train_cnt + TCW'(1);
            sym         = IDLE_SYMBOL;
            sym_start_n = 1'b1;
            if (train_cnt == TCW'(TRAIN_SYMBOLS - 1)) state_n = ACTIVE;
          end
        end
        ACTIVE: begin
          if (!enable) begin
            state_n     = IDLE;
            train_cnt_n = '0;
          end else begin
            sym         = valid_in ? data_in : IDLE_SYMBOL;
            sym_start_n = 1'b1;
            collision_n = valid_in && (data_in == IDLE_SYMBOL);
          end
        end
        default: begin
          state_n     = IDLE;
          train_cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      bit_cnt   <= 3'd7;
      train_cnt <= '0;
      sym_start <= 1'b0;
      collision <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt - 3'd1;
      train_cnt <= train_cnt_n;
      sym_start <= sym_start_n;
      collision <= collision_n;
    end
  end

  shift_reg_piso u_piso (
    .clk   (clk_32f),
    .rst_n (reset_L),
    .load  (boundary),
    .sym   (sym),
    .ser   (data_out)
  );
endmodule

// File: tb/tb_paralelo_serial.sv
// Bench for paralelo_serial: symbol-level reference model checked every cycle,
// a table of ACTIVE-phase symbols, and hand sequences for enable/reset corners.
module tb_paralelo_serial;
  localparam int TRAIN = 8;
  localparam logic [7:0] COM = 8'hBC;

  logic clk_32f = 1'b0;
  logic reset_L, enable, valid_in;
  logic [7:0] data_in;
  logic ready_out, data_out, sym_start, active_out, collision;

  paralelo_serial #(.TRAIN_SYMBOLS(TRAIN), .IDLE_SYMBOL(COM)) dut (
    .clk_32f(clk_32f), .reset_L(reset_L), .enable(enable), .valid_in(valid_in),
    .data_in(data_in), .ready_out(ready_out), .data_out(data_out),
    .sym_start(sym_start), .active_out(active_out), .collision(collision)
  );

  always #5 clk_32f = ~clk_32f;

  int n_chk = 0, n_fail = 0;

  // Reference model: edges since reset, COMs sent so far, whether data is being taken.
  int         nedge, coms, k;
  bit         live;
  logic [7:0] cur, rx_bits;
  logic       e_do, e_ss, e_col, load_col;

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic [7:0] exp_sym;
    logic       exp_col;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    nedge = 0; coms = 0; live = 0; cur = 8'h00; k = 8; rx_bits = 8'h00;
  endtask

  // One clock: check combinational outputs, predict the edge, check registered outputs.
  task automatic tick();
    bit bnd;
    logic [7:0] s;
    bnd = (nedge % 8) == 7;
    chk("ready_out", {7'd0, ready_out}, {7'd0, live && bnd && enable});
    chk("active_out", {7'd0, active_out}, {7'd0, live});
    e_ss = 1'b0; e_col = 1'b0;
    if (bnd) begin
      if (!enable) begin
        live = 0; coms = 0; s = 8'h00;
      end else if (live) begin
        s = valid_in ? data_in : COM;
        e_col = valid_in && (data_in == COM);
        e_ss = 1'b1;
      end else begin
        coms++; s = COM; e_ss = 1'b1;
        if (coms == TRAIN) live = 1;
      end
      cur = s; k = 0;
    end else if (k < 8) k++;
    e_do = (k < 8) ? cur[7-k] : 1'b0;
    @(posedge clk_32f);
    nedge++;
    @(negedge clk_32f);
    chk("data_out", {7'd0, data_out}, {7'd0, e_do});
    chk("sym_start", {7'd0, sym_start}, {7'd0, e_ss});
    chk("collision", {7'd0, collision}, {7'd0, e_col});
    rx_bits = {rx_bits[6:0], data_out};
    if (bnd) load_col = collision;
  endtask

  // Advance until the cycle where bit_cnt equals bc (never more than 8 clocks).
  task automatic align(input int bc);
    for (int i = 0; i < 8; i++) begin
      if (7 - (nedge % 8) == bc) break;
      tick();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " data_out"}, {7'd0, data_out}, 8'd0);
    chk({tag, " sym_start"}, {7'd0, sym_start}, 8'd0);
    chk({tag, " ready_out"}, {7'd0, ready_out}, 8'd0);
    chk({tag, " active_out"}, {7'd0, active_out}, 8'd0);
    chk({tag, " collision"}, {7'd0, collision}, 8'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, starts;
    vecs[0] = '{1'b1, 8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 8'h3C, 8'h3C, 1'b0};
    vecs[2] = '{1'b0, 8'h77, 8'hBC, 1'b0};
    vecs[3] = '{1'b1, 8'hBC, 8'hBC, 1'b1};
    vecs[4] = '{1'b1, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 8'hFF, 8'hFF, 1'b0};

    reset_L = 1'b0; enable = 1'b0; valid_in = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk_32f);
    chk_reset_vals("reset");
    reset_L = 1'b1;
    model_reset();

    // Training burst: active_out must rise on the 64th edge (load edge of the 8th COM).
    enable = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (active_out) begin cyc = i; break; end
    end
    chk("train_len", cyc[7:0], 8'd64);
    repeat (16) tick();

    // Table: one symbol per boundary; inputs scrambled mid-symbol to show they are ignored.
    foreach (vecs[i]) begin
      align(0);
      valid_in = vecs[i].vld; data_in = vecs[i].data;
      tick();
      for (int b = 0; b < 7; b++) begin
        valid_in = $urandom_range(0, 1); data_in = 8'($urandom);
        tick();
      end
      chk("vec_sym", rx_bits, vecs[i].exp_sym);
      chk("vec_col", {7'd0, load_col}, {7'd0, vecs[i].exp_col});
    end

    // valid_in high only at bit_cnt 4: nothing accepted, COM goes out.
    align(0);
    valid_in = 1'b0; tick();
    align(4);
    valid_in = 1'b1; data_in = 8'h55; tick();
    valid_in = 1'b0;
    align(0);
    tick();
    repeat (7) tick();
    chk("no_accept_sym", rx_bits, COM);

    // enable drop at bit_cnt 3: symbol finishes, then zeros and leave ACTIVE.
    align(3);
    enable = 1'b0;
    repeat (24) tick();
    chk("disabled_active", {7'd0, active_out}, 8'd0);
    chk("disabled_bits", rx_bits, 8'h00);

    // Re-enable: a full burst of TRAIN COMs precedes ACTIVE.
    enable = 1'b1;
    starts = 0; cyc = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (sym_start) starts++;
      if (active_out) begin cyc = i; break; end
    end
    chk("retrain_coms", starts[7:0], 8'(TRAIN));
    repeat (8) tick();

    // Reset asserted at bit_cnt 5 while a COM bit '1' is on the wire.
    align(5);
    chk("pre_reset_bit", {7'd0, data_out}, 8'd1);
    reset_L = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk_32f);
    reset_L = 1'b1;
    model_reset();
    repeat (7) tick();
    chk("restart_quiet", {7'd0, sym_start}, 8'd0);
    tick();
    chk("restart_8th", {7'd0, sym_start}, 8'd1);

    // Random traffic with rare enable drops.
    for (int i = 0; i < 1500; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      data_in  = ($urandom_range(0, 7) == 0) ? COM : 8'($urandom);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 15) == 0) enable = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
